// File: rtl/sync_reg_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_reg_fifo
// Purpose  : Single-clock register-based FIFO with arbitrary depth, occupancy
//            count, programmable almost-full/almost-empty thresholds,
//            synchronous flush, overflow/underflow error pulses and a
//            read-valid qualifier.
// Config   : SYNC_REG_FIFO_FWFT_EN - when defined, first-word-fall-through
//            mode (rdDataOut shows the head word combinationally and
//            rdEnIn acknowledges it). Undefined: registered read with
//            1-cycle latency.
// Ports    : clkIn         - clock, rising edge
//            rstIn         - asynchronous active-high reset
//            clrIn         - synchronous flush (pointers and count to 0)
//            wrDataIn      - write data
//            wrEnIn        - write request
//            rdEnIn        - read request / acknowledge in FWFT mode
//            rdDataOut     - read data
//            rdValidOut    - rdDataOut holds valid data
//            fifoCntOut    - occupancy, 0..FIFO_DEPTH
//            fifoFullOut   - count == FIFO_DEPTH
//            fifoEmptyOut  - count == 0
//            fifoAFullOut  - count >= AFULL_THRESH
//            fifoAEmptyOut - count <= AEMPTY_THRESH
//            overflowOut   - one-cycle pulse after a rejected write
//            underflowOut  - one-cycle pulse after a rejected read
// Revision : 1.0 - initial release
// ============================================================================
module sync_reg_fifo #(
    parameter int FIFO_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    localparam int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  clrIn,
    input  logic [FIFO_WIDTH-1:0] wrDataIn,
    input  logic                  wrEnIn,
    input  logic                  rdEnIn,
    output logic [FIFO_WIDTH-1:0] rdDataOut,
    output logic                  rdValidOut,
    output logic [CNT_W-1:0]      fifoCntOut,
    output logic                  fifoFullOut,
    output logic                  fifoEmptyOut,
    output logic                  fifoAFullOut,
    output logic                  fifoAEmptyOut,
    output logic                  overflowOut,
    output logic                  underflowOut
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] c_fullCnt   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] c_afullCnt  = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] c_aemptyCnt = CNT_W'(AEMPTY_THRESH);
    localparam logic [PTR_W-1:0] c_lastPtr   = PTR_W'(FIFO_DEPTH - 1);

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wrPtr;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wrAcc;
    logic w_rdAcc;

    // Pointers wrap explicitly at FIFO_DEPTH-1 so non-power-of-two depths
    // never address past the last entry.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == c_lastPtr) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign w_full  = (r_cnt == c_fullCnt);
    assign w_empty = (r_cnt == '0);

    // Flush wins over both requests; flags come from registered state only,
    // so a read while full does not make room for a same-cycle write.
    assign w_wrAcc = wrEnIn && !w_full  && !clrIn;
    assign w_rdAcc = rdEnIn && !w_empty && !clrIn;

    // ------------------------------------------------------------------
    // Pointers, count and error pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_cnt       <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clrIn) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_cnt       <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wrAcc) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (w_rdAcc) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            case ({w_wrAcc, w_rdAcc})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
            r_overflow  <= wrEnIn && w_full;
            r_underflow <= rdEnIn && w_empty;
        end
    end

    // ------------------------------------------------------------------
    // Storage (contents survive a flush; only reset clears them)
    // ------------------------------------------------------------------
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wrAcc) begin
            r_mem[r_wrPtr] <= wrDataIn;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
`ifdef SYNC_REG_FIFO_FWFT_EN
    // Head word is always presented; rdEnIn only pops it.
    assign rdDataOut  = r_mem[r_rdPtr];
    assign rdValidOut = !w_empty;
`else
    logic [FIFO_WIDTH-1:0] r_rdData;
    logic                  r_rdValid;

    // rdDataOut holds its last value when no read is accepted (including
    // rejected reads and flushes); rdValidOut qualifies it for one cycle.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
        end else begin
            r_rdValid <= w_rdAcc;
            if (w_rdAcc) begin
                r_rdData <= r_mem[r_rdPtr];
            end
        end
    end

    assign rdDataOut  = r_rdData;
    assign rdValidOut = r_rdValid;
`endif

    // ------------------------------------------------------------------
    // Status outputs, decoded from the registered count
    // ------------------------------------------------------------------
    assign fifoCntOut    = r_cnt;
    assign fifoFullOut   = w_full;
    assign fifoEmptyOut  = w_empty;
    assign fifoAFullOut  = (r_cnt >= c_afullCnt);
    assign fifoAEmptyOut = (r_cnt <= c_aemptyCnt);
    assign overflowOut   = r_overflow;
    assign underflowOut  = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_reg_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_reg_fifo
// Purpose  : Self-checking bench for sync_reg_fifo (WIDTH=8, DEPTH=6,
//            AFULL=4, AEMPTY=1). A queue models the FIFO contents; every
//            accepted write is pushed and every accepted read pops the
//            word the DUT must return. Builds in either read mode
//            (SYNC_REG_FIFO_FWFT_EN defined or not).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_reg_fifo;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 6;
    localparam int AFULL  = 4;
    localparam int AEMPTY = 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic             clkIn = 1'b0;
    logic             rstIn;
    logic             clrIn;
    logic [WIDTH-1:0] wrDataIn;
    logic             wrEnIn;
    logic             rdEnIn;
    logic [WIDTH-1:0] rdDataOut;
    logic             rdValidOut;
    logic [CNT_W-1:0] fifoCntOut;
    logic             fifoFullOut;
    logic             fifoEmptyOut;
    logic             fifoAFullOut;
    logic             fifoAEmptyOut;
    logic             overflowOut;
    logic             underflowOut;

    int checkCnt = 0;
    int failCnt  = 0;

    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] expData  = '0;
    logic             expValid = 1'b0;

    sync_reg_fifo #(
        .FIFO_WIDTH   (WIDTH),
        .FIFO_DEPTH   (DEPTH),
        .AFULL_THRESH (AFULL),
        .AEMPTY_THRESH(AEMPTY)
    ) dut (
        .clkIn        (clkIn),
        .rstIn        (rstIn),
        .clrIn        (clrIn),
        .wrDataIn     (wrDataIn),
        .wrEnIn       (wrEnIn),
        .rdEnIn       (rdEnIn),
        .rdDataOut    (rdDataOut),
        .rdValidOut   (rdValidOut),
        .fifoCntOut   (fifoCntOut),
        .fifoFullOut  (fifoFullOut),
        .fifoEmptyOut (fifoEmptyOut),
        .fifoAFullOut (fifoAFullOut),
        .fifoAEmptyOut(fifoAEmptyOut),
        .overflowOut  (overflowOut),
        .underflowOut (underflowOut)
    );

    always #5 clkIn = ~clkIn;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        if (obs !== exp) begin
            failCnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Compare every output against the model state.
    task automatic checkOutputs(input logic expOvf, input logic expUdf);
        int n;
        n = sb.size();
        checkVal("count",     32'(fifoCntOut),    32'(n));
        checkVal("full",      32'(fifoFullOut),   32'(n == DEPTH));
        checkVal("empty",     32'(fifoEmptyOut),  32'(n == 0));
        checkVal("afull",     32'(fifoAFullOut),  32'(n >= AFULL));
        checkVal("aempty",    32'(fifoAEmptyOut), 32'(n <= AEMPTY));
        checkVal("overflow",  32'(overflowOut),   32'(expOvf));
        checkVal("underflow", 32'(underflowOut),  32'(expUdf));
`ifdef SYNC_REG_FIFO_FWFT_EN
        checkVal("rdValid", 32'(rdValidOut), 32'(n != 0));
        if (n != 0) begin
            checkVal("rdData", 32'(rdDataOut), 32'(sb[0]));
        end
`else
        checkVal("rdValid", 32'(rdValidOut), 32'(expValid));
        checkVal("rdData",  32'(rdDataOut),  32'(expData));
`endif
    endtask

    // One clock cycle of stimulus; the model decides acceptance from the
    // pre-edge occupancy, then the outputs are checked 1 time unit after
    // the edge.
    task automatic step(input logic wr, input logic [WIDTH-1:0] d, input logic rd, input logic clr);
        logic full, empty, wa, ra, expOvf, expUdf;
        wrEnIn   = wr;
        wrDataIn = d;
        rdEnIn   = rd;
        clrIn    = clr;
        full   = (sb.size() == DEPTH);
        empty  = (sb.size() == 0);
        wa     = wr && !full  && !clr;
        ra     = rd && !empty && !clr;
        expOvf = wr && full  && !clr;
        expUdf = rd && empty && !clr;
        @(posedge clkIn);
        #1;
        if (clr) begin
            sb.delete();
        end else begin
            if (ra) expData = sb.pop_front();
            if (wa) sb.push_back(d);
        end
        expValid = ra;
        wrEnIn = 1'b0;
        rdEnIn = 1'b0;
        clrIn  = 1'b0;
        checkOutputs(expOvf, expUdf);
    endtask

    task automatic wr(input logic [WIDTH-1:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic rd();
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic drain();
        while (sb.size() != 0) rd();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstIn    = 1'b1;
        clrIn    = 1'b0;
        wrDataIn = '0;
        wrEnIn   = 1'b0;
        rdEnIn   = 1'b0;

        // Reset state
        repeat (2) @(posedge clkIn);
        #1;
        checkOutputs(1'b0, 1'b0);
        rstIn = 1'b0;

        // Fill then drain
        for (int i = 0; i < DEPTH; i++) wr(8'h11 + 8'(i));
        drain();

        // Wrap-around: pointers at 4 before the 6-word burst wraps 5->0
        for (int i = 0; i < 4; i++) wr(8'h30 + 8'(i));
        drain();
        for (int i = 0; i < DEPTH; i++) wr(8'hA0 + 8'(i));
        drain();

        // Overflow (twice, pulse re-asserts) and underflow
        for (int i = 0; i < DEPTH; i++) wr(8'h40 + 8'(i));
        wr(8'h77);
        wr(8'h77);
        step(1'b0, '0, 1'b0, 1'b0);
        drain();
        rd();
        rd();
        step(1'b0, '0, 1'b0, 1'b0);

        // Simultaneous read and write at count 3, 6 and 0
        for (int i = 0; i < 3; i++) wr(8'h50 + 8'(i));
        step(1'b1, 8'h53, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) wr(8'h54 + 8'(i));
        step(1'b1, 8'h77, 1'b1, 1'b0);
        drain();
        step(1'b1, 8'h5F, 1'b1, 1'b0);
        drain();

        // Flush with a concurrent write at count 3
        for (int i = 0; i < 3; i++) wr(8'h60 + 8'(i));
        step(1'b1, 8'h99, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        wr(8'h65);
        rd();

        // FWFT-style head presentation then acknowledge (also exercises the
        // registered read path in the default build)
        wr(8'h5A);
        rd();

        // Asynchronous reset in the middle of a write burst
        for (int i = 0; i < 3; i++) wr(8'h70 + 8'(i));
        rd();
        wrEnIn   = 1'b1;
        wrDataIn = 8'hEE;
        rstIn    = 1'b1;
        #2;
        sb.delete();
        expData  = '0;
        expValid = 1'b0;
        checkOutputs(1'b0, 1'b0);
        @(posedge clkIn);
        #1;
        rstIn  = 1'b0;
        wrEnIn = 1'b0;
        checkOutputs(1'b0, 1'b0);
        wr(8'h81);
        wr(8'h82);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
        $finish;
    end

endmodule
`default_nettype wire
